// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns fetch PC, IF/ID register, downstream stage valids and perf counters.
// Latency: IF/ID is valid one cycle after an accepted fetch; stage valids advance one stage per cycle.
// Backpressure: imem_ready_i low or stall_i high holds the PC; a redirect during an open fetch drops its response.
module pipe_ctrl #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h1c000000,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic [3:0]           flush_i,
    input  logic                 jump_i,
    input  logic [PC_WIDTH-1:0]  jump_target_i,
    input  logic                 imem_ready_i,
    input  logic [31:0]          imem_rdata_i,
    output logic                 imem_req_o,
    output logic [PC_WIDTH-1:0]  imem_addr_o,
    output logic                 ifid_valid_o,
    output logic [PC_WIDTH-1:0]  ifid_pc_o,
    output logic [31:0]          ifid_instr_o,
    output logic                 idex_valid_o,
    output logic                 exmem_valid_o,
    output logic                 memwb_valid_o,
    output logic [CNT_WIDTH-1:0] retire_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] redir_cnt_o
);

    typedef enum logic {RUN, DROP} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] redir_pc;

    assign imem_req_o  = ~rst;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            redir_pc      <= '0;
            ifid_valid_o  <= 1'b0;
            ifid_pc_o     <= '0;
            ifid_instr_o  <= '0;
            idex_valid_o  <= 1'b0;
            exmem_valid_o <= 1'b0;
            memwb_valid_o <= 1'b0;
            retire_cnt_o  <= '0;
            stall_cnt_o   <= '0;
            redir_cnt_o   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (jump_i && imem_ready_i) begin
                        pc <= jump_target_i;
                    end else if (jump_i) begin
                        // The open fetch must complete before the PC may move.
                        redir_pc <= jump_target_i;
                        state    <= DROP;
                    end else if (!stall_i && imem_ready_i) begin
                        pc <= pc + PC_WIDTH'(4);
                    end
                end
                DROP: begin
                    if (imem_ready_i) begin
                        pc    <= jump_i ? jump_target_i : redir_pc;
                        state <= RUN;
                    end else if (jump_i) begin
                        redir_pc <= jump_target_i;
                    end
                end
                default: state <= RUN;
            endcase

            if (flush_i[3] || jump_i || state == DROP) begin
                ifid_valid_o <= 1'b0;
            end else if (stall_i) begin
                ifid_valid_o <= ifid_valid_o;
            end else if (imem_ready_i) begin
                ifid_valid_o <= 1'b1;
                ifid_pc_o    <= pc;
                ifid_instr_o <= imem_rdata_i;
            end else begin
                ifid_valid_o <= 1'b0;
            end

            idex_valid_o  <= ifid_valid_o  & ~(flush_i[2] | stall_i);
            exmem_valid_o <= idex_valid_o  & ~flush_i[1];
            memwb_valid_o <= exmem_valid_o & ~flush_i[0];

            if (memwb_valid_o) retire_cnt_o <= retire_cnt_o + CNT_WIDTH'(1);
            if (stall_i)       stall_cnt_o  <= stall_cnt_o  + CNT_WIDTH'(1);
            if (jump_i)        redir_cnt_o  <= redir_cnt_o  + CNT_WIDTH'(1);
        end
    end

endmodule
